baccarat_dealer: RTL and testbench



---
 rtl/baccarat_pkg.sv | 39 +++
 rtl/baccarat_dealer_if.sv | 21 ++
 rtl/card_source.sv | 26 ++
 rtl/scorehand.sv | 22 ++
 rtl/baccarat_dealer.sv | 104 ++++++++++
 tb/tb_baccarat_dealer.sv | 259 +++++++++++++++++++++++++
 6 files changed

// File: rtl/baccarat_pkg.sv
// Shared types, card constants and scoring helpers for the baccarat dealer.
package baccarat_pkg;

  typedef enum logic [3:0] {
    StDealP1,
    StDealD1,
    StDealP2,
    StDealD2,
    StEval,
    StDealP3,
    StBank,
    StDealD3,
    StDone
  } deal_state_t;

  localparam logic [3:0] CARD_NONE = 4'd0;
  localparam logic [3:0] CARD_MAX  = 4'd13;

  // Pips count face value; tens, faces and empty slots count zero.
  function automatic logic [3:0] card_value(input logic [3:0] card);
    return (card >= 4'd1 && card <= 4'd9) ? card : 4'd0;
  endfunction

  // Banker's third-card decision given its score and the player's third-card value.
  function automatic logic banker_draws(input logic [3:0] dscore, input logic [3:0] v);
    logic draw;
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
      default:          draw = 1'b0;
    endcase
    return draw;
  endfunction

endpackage

// File: rtl/baccarat_dealer_if.sv
// Card/result bundle between the dealer (master) and its consumer (slave).
interface baccarat_dealer_if;
  logic       step;
  logic [3:0] pcard1, pcard2, pcard3;
  logic [3:0] dcard1, dcard2, dcard3;
  logic [3:0] pscore, dscore;
  logic       done;
  logic       player_win, dealer_win;

  modport master (
    input  step,
    output pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
    output pscore, dscore, done, player_win, dealer_win
  );

  modport slave (
    output step,
    input  pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
    input  pscore, dscore, done, player_win, dealer_win
  );
endinterface

// File: rtl/card_source.sv
// Free-running 1..13 card counter; the current value is the card dealt on a deal edge.
module card_source
  import baccarat_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [3:0] card_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q >= CARD_MAX) ? 4'd1 : cnt_q + 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= 4'd1;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign card_o = cnt_q;

endmodule

// File: rtl/scorehand.sv
// Baccarat hand total: sum of three card values modulo 10.
module scorehand
  import baccarat_pkg::*;
(
  input  logic [3:0] card1_i,
  input  logic [3:0] card2_i,
  input  logic [3:0] card3_i,
  output logic [3:0] total_o
);

  logic [4:0] sum;
  logic [4:0] total;

  always_comb begin
    sum   = {1'b0, card_value(card1_i)} + {1'b0, card_value(card2_i)}
          + {1'b0, card_value(card3_i)};
    total = sum % 5'd10;
  end

  assign total_o = total[3:0];

endmodule

// File: rtl/baccarat_dealer.sv
// Baccarat dealer: deals cards in order, applies third-card rules, reports the winner.
module baccarat_dealer
  import baccarat_pkg::*;
(
  input  logic                      slow_clock,
  input  logic                      resetb,
  baccarat_dealer_if.master         bus
);

  deal_state_t state_q;
  logic [3:0]  pcard1_q, pcard2_q, pcard3_q;
  logic [3:0]  dcard1_q, dcard2_q, dcard3_q;
  logic        done_q;
  logic [3:0]  card;
  logic [3:0]  pscore, dscore;

  card_source u_card_source (
    .clk_i  (slow_clock),
    .rst_ni (resetb),
    .card_o (card)
  );

  scorehand u_pscore (
    .card1_i (pcard1_q),
    .card2_i (pcard2_q),
    .card3_i (pcard3_q),
    .total_o (pscore)
  );

  scorehand u_dscore (
    .card1_i (dcard1_q),
    .card2_i (dcard2_q),
    .card3_i (dcard3_q),
    .total_o (dscore)
  );

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      state_q  <= StDealP1;
      pcard1_q <= CARD_NONE;
      pcard2_q <= CARD_NONE;
      pcard3_q <= CARD_NONE;
      dcard1_q <= CARD_NONE;
      dcard2_q <= CARD_NONE;
      dcard3_q <= CARD_NONE;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        StDealP1: if (bus.step) begin pcard1_q <= card; state_q <= StDealD1; end
        StDealD1: if (bus.step) begin dcard1_q <= card; state_q <= StDealP2; end
        StDealP2: if (bus.step) begin pcard2_q <= card; state_q <= StDealD2; end
        StDealD2: if (bus.step) begin dcard2_q <= card; state_q <= StEval;   end
        StEval: begin
          // Naturals end the hand before either side considers a third card.
          if (pscore >= 4'd8 || dscore >= 4'd8) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else if (pscore <= 4'd5) begin
            state_q <= StDealP3;
          end else if (dscore <= 4'd5) begin
            state_q <= StDealD3;
          end else begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDealP3: if (bus.step) begin pcard3_q <= card; state_q <= StBank; end
        StBank: begin
          if (banker_draws(dscore, card_value(pcard3_q))) begin
            state_q <= StDealD3;
          end else begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDealD3: begin
          if (bus.step) begin
            dcard3_q <= card;
            state_q  <= StDone;
            done_q   <= 1'b1;
          end
        end
        StDone:   ;
        default: begin
          state_q <= StDealP1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pcard1     = pcard1_q;
  assign bus.pcard2     = pcard2_q;
  assign bus.pcard3     = pcard3_q;
  assign bus.dcard1     = dcard1_q;
  assign bus.dcard2     = dcard2_q;
  assign bus.dcard3     = dcard3_q;
  assign bus.pscore     = pscore;
  assign bus.dscore     = dscore;
  assign bus.done       = done_q;
  assign bus.player_win = done_q & (pscore >= dscore);
  assign bus.dealer_win = done_q & (dscore >= pscore);

endmodule

// File: tb/tb_baccarat_dealer.sv
// Self-checking bench for baccarat_dealer: rule-level hand model plus directed hands.
module tb_baccarat_dealer;

  logic slow_clock = 1'b0;
  logic resetb     = 1'b0;

  baccarat_dealer_if bus ();

  baccarat_dealer dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .bus        (bus)
  );

  always #5 slow_clock = ~slow_clock;

  int n_total = 0;
  int n_pass  = 0;

  // Model: counter value, cards dealt so far and the next thing the table does.
  // m_next: 0..3 first four deals, 4 evaluate, 5 player third, 6 banker rule,
  // 7 banker third, 8 hand over.
  int m_cnt   = 0;
  int m_next  = 0;
  bit m_valid = 1'b0;
  int m_p[3];
  int m_d[3];

  function automatic int val(input int c);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction

  function automatic int hand(input int a, input int b, input int c);
    return (val(a) + val(b) + val(c)) % 10;
  endfunction

  // Banker draw table as masks over the player's third-card value 0..9.
  function automatic bit bank_table(input int d, input int v);
    logic [9:0] m;
    case (d)
      0, 1, 2: m = 10'h3FF;
      3:       m = 10'h2FF;
      4:       m = 10'h0FC;
      5:       m = 10'h0F0;
      6:       m = 10'h0C0;
      default: m = 10'h000;
    endcase
    return m[v];
  endfunction

  function automatic bit dealing(input int n);
    return (n <= 3) || (n == 5) || (n == 7);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input int exp);
    n_total++;
    if (act !== 8'(exp)) begin
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_edge();
    int c, ps, ds;
    if (!resetb) begin
      m_valid = 1'b1;
      m_cnt   = 1;
      m_next  = 0;
      for (int i = 0; i < 3; i++) begin m_p[i] = 0; m_d[i] = 0; end
    end else if (m_valid) begin
      c     = m_cnt;
      m_cnt = (m_cnt == 13) ? 1 : m_cnt + 1;
      ps    = hand(m_p[0], m_p[1], m_p[2]);
      ds    = hand(m_d[0], m_d[1], m_d[2]);
      if (dealing(m_next) && bus.step) begin
        case (m_next)
          0: m_p[0] = c;
          1: m_d[0] = c;
          2: m_p[1] = c;
          3: m_d[1] = c;
          5: m_p[2] = c;
          default: m_d[2] = c;
        endcase
        m_next = (m_next == 7) ? 8 : m_next + 1;
      end else if (m_next == 4) begin
        if (ps >= 8 || ds >= 8) m_next = 8;
        else if (ps <= 5)       m_next = 5;
        else if (ds <= 5)       m_next = 7;
        else                    m_next = 8;
      end else if (m_next == 6) begin
        m_next = bank_table(ds, val(m_p[2])) ? 7 : 8;
      end
    end
  endtask

  task automatic compare();
    int  ps, ds;
    bit  dn;
    ps = hand(m_p[0], m_p[1], m_p[2]);
    ds = hand(m_d[0], m_d[1], m_d[2]);
    dn = (m_next == 8);
    check("pcard1", bus.pcard1, m_p[0]);
    check("pcard2", bus.pcard2, m_p[1]);
    check("pcard3", bus.pcard3, m_p[2]);
    check("dcard1", bus.dcard1, m_d[0]);
    check("dcard2", bus.dcard2, m_d[1]);
    check("dcard3", bus.dcard3, m_d[2]);
    check("pscore", bus.pscore, ps);
    check("dscore", bus.dscore, ds);
    check("done", bus.done, int'(dn));
    check("player_win", bus.player_win, int'(dn && ps >= ds));
    check("dealer_win", bus.dealer_win, int'(dn && ds >= ps));
  endtask

  initial forever begin
    @(posedge slow_clock);
    model_edge();
  end

  initial forever begin
    @(negedge slow_clock);
    if (m_valid) compare();
  end

  // step is driven high through the reset edges to show it is ignored there.
  task automatic do_reset(input logic step_at_release);
    resetb   = 1'b0;
    bus.step = 1'b1;
    repeat (2) @(negedge slow_clock);
    resetb   = 1'b1;
    bus.step = step_at_release;
  endtask

  task automatic deal(input int x, input int cycles);
    int n;
    n = 0;
    bus.step = 1'b0;
    while (!(dealing(m_next) && m_cnt == x) && n < 40) begin
      @(negedge slow_clock);
      n++;
    end
    if (n >= 40) check("deal_timeout", 8'd1, 0);
    bus.step = 1'b1;
    repeat (cycles) @(negedge slow_clock);
    bus.step = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 30) begin
      @(negedge slow_clock);
      n++;
    end
    if (bus.done !== 1'b1) check("done_timeout", 8'd1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.step = 1'b0;

    // Reset state, then the first deal takes the post-reset counter value 1.
    do_reset(1'b1);
    check("rst_pcard1", bus.pcard1, 0);
    check("rst_done", bus.done, 0);
    check("rst_pscore", bus.pscore, 0);
    @(negedge slow_clock);
    bus.step = 1'b0;
    check("first_card", bus.pcard1, 1);

    // Natural: P 4,4  D 2,3.
    do_reset(1'b0);
    deal(4, 1); deal(2, 1); deal(4, 1); deal(3, 1);
    wait_done();
    check("nat_pscore", bus.pscore, 8);
    check("nat_dscore", bus.dscore, 5);
    check("nat_pcard3", bus.pcard3, 0);
    check("nat_dcard3", bus.dcard3, 0);
    check("nat_pwin", bus.player_win, 1);
    check("nat_dwin", bus.dealer_win, 0);

    // Player draws 9, banker on 7 stands.
    do_reset(1'b0);
    deal(2, 1); deal(3, 1); deal(3, 1); deal(4, 1); deal(9, 1);
    wait_done();
    check("h2_pscore", bus.pscore, 4);
    check("h2_dscore", bus.dscore, 7);
    check("h2_dwin", bus.dealer_win, 1);
    check("h2_pwin", bus.player_win, 0);

    // Faces score 0; banker on 3 stands against a third card of 8.
    do_reset(1'b0);
    deal(11, 1); deal(1, 1); deal(12, 1); deal(2, 1); deal(8, 1);
    wait_done();
    check("h3_pscore", bus.pscore, 8);
    check("h3_dscore", bus.dscore, 3);
    check("h3_dcard3", bus.dcard3, 0);
    check("h3_pwin", bus.player_win, 1);

    // Player stands on 6, banker draws 4.
    do_reset(1'b0);
    deal(3, 1); deal(1, 1); deal(3, 1); deal(2, 1); deal(4, 1);
    wait_done();
    check("h4_dcard3", bus.dcard3, 4);
    check("h4_dscore", bus.dscore, 7);
    check("h4_dwin", bus.dealer_win, 1);
    check("h4_pwin", bus.player_win, 0);

    // Tie at 6 each.
    do_reset(1'b0);
    deal(12, 1); deal(13, 1); deal(6, 1); deal(6, 1);
    wait_done();
    check("tie_pwin", bus.player_win, 1);
    check("tie_dwin", bus.dealer_win, 1);

    // step held high from release: cards 1,2,3,4, EVAL eats 5, P3=6, BANK eats 7, D3=8;
    // it stays high in DONE afterwards.
    do_reset(1'b1);
    wait_done();
    repeat (4) @(negedge slow_clock);
    bus.step = 1'b0;
    check("held_pcard2", bus.pcard2, 3);
    check("held_dcard2", bus.dcard2, 4);
    check("held_pcard3", bus.pcard3, 6);
    check("held_dcard3", bus.dcard3, 8);
    check("held_dscore", bus.dscore, 4);
    check("held_dwin", bus.dealer_win, 1);

    // Counter wrap: back-to-back deals at 13 give 13 then 1.
    do_reset(1'b0);
    deal(13, 2);
    check("wrap_pcard1", bus.pcard1, 13);
    check("wrap_dcard1", bus.dcard1, 1);

    // Reset after DEAL_D1 clears at once and restarts the counter at 1.
    do_reset(1'b0);
    deal(5, 1); deal(7, 1);
    resetb   = 1'b0;
    bus.step = 1'b1;
    @(negedge slow_clock);
    check("mid_pcard1", bus.pcard1, 0);
    check("mid_dcard1", bus.dcard1, 0);
    resetb = 1'b1;
    @(negedge slow_clock);
    bus.step = 1'b0;
    check("mid_restart", bus.pcard1, 1);
    @(negedge slow_clock);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
